ccff_chain_loader: RTL and testbench



---
 rtl/ccff_loader_pkg.sv | 24 ++
 rtl/ccff_crc8_serial.sv | 30 +++
 rtl/ccff_chain_loader.sv | 193 +++++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_CHECK  = 3'd3,
    ST_FIN    = 3'd4
  } ccff_ld_state_t;

  localparam int CRC_W = 8;
  localparam logic [CRC_W-1:0] CRC_POLY_DEFAULT = 8'h07;

  // One bit-serial CRC-8 step, MSB-first Galois form.
  function automatic logic [CRC_W-1:0] crc8_step(
    input logic [CRC_W-1:0] crc,
    input logic             bit_in,
    input logic [CRC_W-1:0] poly
  );
    crc8_step = {crc[CRC_W-2:0], 1'b0} ^ ((crc[CRC_W-1] ^ bit_in) ? poly : {CRC_W{1'b0}});
  endfunction

endpackage

// File: rtl/ccff_crc8_serial.sv
// Bit-serial CRC-8 accumulator; clear takes priority over folding a bit.
module ccff_crc8_serial
  import ccff_loader_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC_POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             bit_en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc_out
);

  logic [CRC_W-1:0] crc_r;

  // CRC register: zero on reset or clear, otherwise fold one bit when enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_r <= {CRC_W{1'b0}};
    end else if (clear) begin
      crc_r <= {CRC_W{1'b0}};
    end else if (bit_en) begin
      crc_r <= crc8_step(crc_r, bit_in, POLY);
    end
  end

  assign crc_out = crc_r;

endmodule

// File: rtl/ccff_chain_loader.sv
// Programming sequencer for one configuration-chain segment: streams
// bitstream words onto the chain, optionally recirculates it once to
// CRC-check the contents, then releases pad isolation.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int               CHAIN_LEN = 4,
  parameter int               WORD_W    = 8,
  parameter logic [CRC_W-1:0] CRC_POLY  = CRC_POLY_DEFAULT
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_clk_en,
  output logic              isol_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CW-1:0] CNT_MAX_C  = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] CNT_LAST_C = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE_C  = CW'(1);
  localparam logic [IW-1:0] IDX_LAST_C = IW'(WORD_W - 1);
  localparam logic [IW-1:0] IDX_ONE_C  = IW'(1);

  ccff_ld_state_t    state_r, state_s;
  logic [WORD_W-1:0] buf_r;
  logic              buf_full_r;
  logic [IW-1:0]     idx_r;
  logic [CW-1:0]     bit_cnt_r, verify_cnt_r;
  logic              verify_en_r, head_hold_r, isol_n_r, error_r;
  logic              start_s, shift_s, recirc_s, final_bit_s, word_end_s, ready_s, accept_s;
  logic              cur_bit_s;
  logic [CRC_W-1:0]  crc_tx_s, crc_rx_s;

  assign cur_bit_s = buf_r[idx_r];
  assign accept_s  = cfg_valid & ready_s;

  // Next state, shift/recirculate strobes and the zero-bubble ready decode
  always_comb begin
    state_s     = state_r;
    start_s     = 1'b0;
    shift_s     = 1'b0;
    recirc_s    = 1'b0;
    final_bit_s = 1'b0;
    word_end_s  = 1'b0;
    ready_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          start_s = 1'b1;
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        shift_s     = buf_full_r && (bit_cnt_r != CNT_MAX_C);
        final_bit_s = shift_s && (bit_cnt_r == CNT_LAST_C);
        word_end_s  = shift_s && (idx_r == IDX_LAST_C);
        // A new word may land while the last bit of the current one shifts,
        // but never once the chain has all the bits it needs.
        if ((bit_cnt_r == CNT_MAX_C) || final_bit_s) begin
          ready_s = 1'b0;
        end else if (!buf_full_r || word_end_s) begin
          ready_s = 1'b1;
        end else begin
          ready_s = 1'b0;
        end
        if (final_bit_s || (bit_cnt_r == CNT_MAX_C)) begin
          state_s = verify_en_r ? ST_VERIFY : ST_FIN;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_VERIFY: begin
        recirc_s = 1'b1;
        if (verify_cnt_r == CNT_LAST_C) begin
          state_s = ST_CHECK;
        end else begin
          state_s = ST_VERIFY;
        end
      end
      ST_CHECK: state_s = ST_FIN;
      ST_FIN:   state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // One-entry word buffer; a partial final word is dropped with the last chain bit
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      buf_r      <= {WORD_W{1'b0}};
      buf_full_r <= 1'b0;
      idx_r      <= {IW{1'b0}};
    end else if (start_s) begin
      buf_full_r <= 1'b0;
      idx_r      <= {IW{1'b0}};
    end else if (accept_s) begin
      buf_r      <= cfg_data;
      buf_full_r <= 1'b1;
      idx_r      <= {IW{1'b0}};
    end else if (final_bit_s || word_end_s) begin
      buf_full_r <= 1'b0;
      idx_r      <= {IW{1'b0}};
    end else if (shift_s) begin
      idx_r <= idx_r + IDX_ONE_C;
    end
  end

  // Saturating bit counters for the load and recirculate passes
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      bit_cnt_r    <= {CW{1'b0}};
      verify_cnt_r <= {CW{1'b0}};
    end else if (start_s) begin
      bit_cnt_r    <= {CW{1'b0}};
      verify_cnt_r <= {CW{1'b0}};
    end else begin
      if (shift_s && (bit_cnt_r != CNT_MAX_C)) begin
        bit_cnt_r <= bit_cnt_r + CNT_ONE_C;
      end
      if (recirc_s && (verify_cnt_r != CNT_MAX_C)) begin
        verify_cnt_r <= verify_cnt_r + CNT_ONE_C;
      end
    end
  end

  // Session flags: latched verify mode, held head bit, sticky error, isolation
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      verify_en_r <= 1'b0;
      head_hold_r <= 1'b0;
      error_r     <= 1'b0;
      isol_n_r    <= 1'b0;
    end else if (start_s) begin
      verify_en_r <= verify_en;
      error_r     <= 1'b0;
      isol_n_r    <= 1'b0;
    end else if (shift_s) begin
      head_hold_r <= cur_bit_s;
    end else if (state_r == ST_CHECK) begin
      error_r <= (crc_tx_s != crc_rx_s);
    end else if (state_r == ST_FIN) begin
      isol_n_r <= ~error_r;
    end
  end

  ccff_crc8_serial #(.POLY(CRC_POLY)) u_crc_tx (
    .clk     (prog_clk),
    .rst     (prog_reset),
    .clear   (start_s),
    .bit_en  (shift_s),
    .bit_in  (cur_bit_s),
    .crc_out (crc_tx_s)
  );

  ccff_crc8_serial #(.POLY(CRC_POLY)) u_crc_rx (
    .clk     (prog_clk),
    .rst     (prog_reset),
    .clear   (start_s),
    .bit_en  (recirc_s),
    .bit_in  (ccff_tail),
    .crc_out (crc_rx_s)
  );

  assign cfg_ready    = ready_s;
  assign chain_clk_en = shift_s | recirc_s;
  assign ccff_head    = shift_s ? cur_bit_s : (recirc_s ? ccff_tail : head_hold_r);
  assign busy         = (state_r != ST_IDLE);
  assign done         = (state_r == ST_FIN);
  assign isol_n       = isol_n_r;
  assign error        = error_r;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a 4-bit and a 12-bit chain instance,
// each with a behavioural shift-register model of the configuration chain.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start4 = 1'b0, ven4 = 1'b0, valid4 = 1'b0, corrupt4 = 1'b0;
  logic [7:0] data4 = 8'h00;
  logic       ready4, head4, tail4, en4, isol4, busy4, done4, err4;
  logic [3:0] ch4 = 4'b0000;

  logic        start12 = 1'b0, ven12 = 1'b0, valid12 = 1'b0;
  logic [7:0]  data12 = 8'h00;
  logic        ready12, head12, tail12, en12, isol12, busy12, done12, err12;
  logic [11:0] ch12 = 12'h000;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ccff_chain_loader #(.CHAIN_LEN(4), .WORD_W(8)) dut4 (
    .prog_clk(clk), .prog_reset(rst), .start(start4), .verify_en(ven4),
    .cfg_data(data4), .cfg_valid(valid4), .cfg_ready(ready4),
    .ccff_head(head4), .ccff_tail(tail4), .chain_clk_en(en4),
    .isol_n(isol4), .busy(busy4), .done(done4), .error(err4)
  );

  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
    .prog_clk(clk), .prog_reset(rst), .start(start12), .verify_en(ven12),
    .cfg_data(data12), .cfg_valid(valid12), .cfg_ready(ready12),
    .ccff_head(head12), .ccff_tail(tail12), .chain_clk_en(en12),
    .isol_n(isol12), .busy(busy12), .done(done12), .error(err12)
  );

  // Chain models: tile0 is the head end, the tail is the last tile
  always @(posedge clk) begin
    if (en4) ch4 <= {ch4[2:0], head4};
    if (en12) ch12 <= {ch12[10:0], head12};
  end
  assign tail4  = ch4[3] ^ corrupt4;
  assign tail12 = ch12[11];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset4(input string tag);
    check_eq({tag, " ready"}, ready4, 0);
    check_eq({tag, " head"},  head4,  0);
    check_eq({tag, " en"},    en4,    0);
    check_eq({tag, " isol_n"}, isol4, 0);
    check_eq({tag, " busy"},  busy4,  0);
    check_eq({tag, " done"},  done4,  0);
    check_eq({tag, " error"}, err4,   0);
  endtask

  // One 4-bit session with word A5; cycle 0 is the start cycle
  task automatic run4(input logic v, input logic corrupt_en, input logic poke, input logic exp_err);
    logic [7:0] w;
    int done_c;
    logic e;
    w = 8'hA5;
    done_c = v ? 11 : 6;
    for (int c = 0; c <= done_c + 1; c++) begin
      @(posedge clk); #1;
      start4   = (c == 0) || (poke && (c == 3));
      ven4     = v;
      data4    = w;
      valid4   = (c <= 1);
      corrupt4 = corrupt_en && (c >= 6) && (c <= 9);
      @(negedge clk);
      e = ((c >= 2) && (c <= 5)) || (v && (c >= 6) && (c <= 9));
      check_eq($sformatf("en4 c%0d", c), en4, e);
      if ((c >= 2) && (c <= 5)) check_eq($sformatf("head4 c%0d", c), head4, w[c-2]);
      if (v && (c >= 6) && (c <= 9)) check_eq($sformatf("recirc4 c%0d", c), head4, tail4);
      if (c <= done_c) begin
        check_eq($sformatf("done4 c%0d", c), done4, (c == done_c));
        check_eq($sformatf("busy4 c%0d", c), busy4, (c >= 1));
      end
      if (c <= 2) check_eq($sformatf("ready4 c%0d", c), ready4, (c == 1));
      if (c == 1) begin
        check_eq("err4 cleared", err4, 0);
        check_eq("isol4 forced", isol4, 0);
      end
      if (c == done_c + 1) begin
        check_eq("err4 end", err4, exp_err);
        check_eq("isol4 end", isol4, !exp_err);
        check_eq("busy4 end", busy4, 0);
        check_eq("done4 end", done4, 0);
      end
    end
    start4 = 1'b0; valid4 = 1'b0; corrupt4 = 1'b0;
  endtask

  // Watchdog so the run cannot hang
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    check_reset4("reset4");
    check_eq("reset12 ready", ready12, 0);
    check_eq("reset12 isol_n", isol12, 0);
    @(negedge clk);
    rst = 1'b0;

    run4(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("chain4 load", ch4, 4'b1010);
    run4(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("chain4 verify", ch4, 4'b1010);
    run4(1'b1, 1'b1, 1'b0, 1'b1);
    run4(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("chain4 reprog", ch4, 4'b1010);

    // Reset after two shifts of a verify session
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk); #1;
      start4 = (c == 0);
      ven4   = 1'b1;
      data4  = 8'hA5;
      valid4 = (c <= 1);
    end
    check_eq("pre-reset en4", en4, 1);
    rst = 1'b1;
    #1;
    check_reset4("midreset4");
    @(negedge clk);
    rst = 1'b0;
    valid4 = 1'b0;
    run4(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("chain4 after reset", ch4, 4'b1010);

    // 12-bit chain: FF, three idle cycles, then 0F whose upper nibble is dropped
    for (int c = 0; c <= 18; c++) begin
      @(posedge clk); #1;
      start12 = (c == 0);
      ven12   = 1'b0;
      data12  = (c <= 8) ? 8'hFF : 8'h0F;
      valid12 = (c <= 8) || (c >= 12);
      @(negedge clk);
      check_eq($sformatf("en12 c%0d", c), en12, ((c >= 2) && (c <= 9)) || ((c >= 13) && (c <= 16)));
      check_eq($sformatf("ready12 c%0d", c), ready12, (c == 1) || ((c >= 9) && (c <= 12)));
      if ((c >= 2) && (c <= 16)) check_eq($sformatf("head12 c%0d", c), head12, 1);
      if (c <= 17) check_eq($sformatf("done12 c%0d", c), done12, (c == 17));
      if (c == 18) begin
        check_eq("isol12 end", isol12, 1);
        check_eq("busy12 end", busy12, 0);
        check_eq("err12 end", err12, 0);
      end
    end
    valid12 = 1'b0;
    check_eq("chain12", ch12, 12'hFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
